// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared AXI3 response/burst encodings and FSM state types for axi3_slave_ram
package axi3_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, byte-enabled write port, synchronous read-first read port
module sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [WIDTH/8-1:0]         wbe,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports update with non-blocking writes, so a same-word collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi3_slave_ram.sv
// rtl/axi3_slave_ram.sv - AXI3 slave memory: independent write/read burst FSMs over an sdp_ram
module axi3_slave_ram
    import axi3_pkg::*;
#(
    parameter int                        ADDR_BUS_WIDTH = 32,
    parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
    parameter int                        DATA_BUS_WIDTH = 32,
    parameter int                        ID_WIDTH       = 3,
    parameter int                        MEM_DEPTH      = 1024
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [ID_WIDTH-1:0]         s_axi_awid,
    input  logic [ADDR_BUS_WIDTH-1:0]   s_axi_awaddr,
    input  logic [3:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [ID_WIDTH-1:0]         s_axi_wid,
    input  logic [DATA_BUS_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_BUS_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [ID_WIDTH-1:0]         s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ID_WIDTH-1:0]         s_axi_arid,
    input  logic [ADDR_BUS_WIDTH-1:0]   s_axi_araddr,
    input  logic [3:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [ID_WIDTH-1:0]         s_axi_rid,
    output logic [DATA_BUS_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int SHIFT = $clog2(DATA_BUS_WIDTH / 8);
    localparam int IW    = $clog2(MEM_DEPTH);

    function automatic resp_t decode(input logic [ADDR_BUS_WIDTH-1:0] addr, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_BUS_WIDTH-1:0] off;
        logic [ADDR_BUS_WIDTH:0]   last;
        off  = addr - BASE_ADDR;
        last = {1'b0, off >> SHIFT} + (ADDR_BUS_WIDTH + 1)'(len);
        if (addr < BASE_ADDR || last >= (ADDR_BUS_WIDTH + 1)'(MEM_DEPTH)) return DECERR;
        if (!(burst == FIXED || burst == INCR) || size != 3'(SHIFT)) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [IW-1:0] word_index(input logic [ADDR_BUS_WIDTH-1:0] addr);
        return IW'((addr - BASE_ADDR) >> SHIFT);
    endfunction

    w_state_t                w_state, w_next;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [IW-1:0]           w_idx;
    logic [3:0]              aw_len, w_cnt;
    logic                    aw_fixed, w_over;
    resp_t                   w_err, bresp;
    logic                    aw_hs, w_hs, w_beat_bad, ram_we;

    r_state_t                r_state, r_next;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [IW-1:0]           r_idx;
    logic [3:0]              ar_len, r_cnt;
    logic                    ar_fixed, r_done, s1_valid, s1_last;
    resp_t                   r_err;
    logic                    ar_hs, r_advance, ram_re;
    logic [DATA_BUS_WIDTH-1:0] ram_rdata;

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    // A beat is bad on id mismatch, once past awlen, or when wlast disagrees with the beat position.
    assign w_beat_bad = (s_axi_wid != aw_id) || w_over || (s_axi_wlast != (w_cnt == aw_len));
    assign ram_we     = w_hs && (w_err == OKAY) && !w_beat_bad;
    assign s_axi_bid  = aw_id;
    assign s_axi_bresp = bresp;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
            W_RESP:  if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) w_state <= W_IDLE;
        else              w_state <= w_next;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            bresp         <= OKAY;
            aw_id         <= '0;
            w_idx         <= '0;
            aw_len        <= '0;
            aw_fixed      <= 1'b0;
            w_cnt         <= '0;
            w_over        <= 1'b0;
            w_err         <= OKAY;
        end else begin
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                aw_id    <= s_axi_awid;
                w_idx    <= word_index(s_axi_awaddr);
                aw_len   <= s_axi_awlen;
                aw_fixed <= (s_axi_awburst == FIXED);
                w_cnt    <= '0;
                w_over   <= 1'b0;
                w_err    <= decode(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 4'd1;
                if (!aw_fixed) w_idx <= w_idx + IW'(1);
                if (w_cnt == aw_len && !s_axi_wlast) w_over <= 1'b1;
                if (w_beat_bad && w_err == OKAY) w_err <= SLVERR;
                if (s_axi_wlast) bresp <= (w_beat_bad && w_err == OKAY) ? SLVERR : w_err;
            end
        end
    end

    // Two-stage read pipeline: RAM output (s1) then the R output register; both stall together.
    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign r_advance   = !s_axi_rvalid || s_axi_rready;
    assign ram_re      = (r_state == R_DATA) && r_advance && !r_done;
    assign s_axi_rid   = ar_id;
    assign s_axi_rresp = r_err;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s_axi_rvalid && s_axi_rready && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            ar_id         <= '0;
            r_idx         <= '0;
            ar_len        <= '0;
            ar_fixed      <= 1'b0;
            r_err         <= OKAY;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
        end else begin
            s_axi_arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                ar_id    <= s_axi_arid;
                r_idx    <= word_index(s_axi_araddr);
                ar_len   <= s_axi_arlen;
                ar_fixed <= (s_axi_arburst == FIXED);
                r_err    <= decode(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                r_cnt    <= '0;
                r_done   <= 1'b0;
            end
            if (ram_re) begin
                r_cnt   <= r_cnt + 4'd1;
                if (!ar_fixed) r_idx <= r_idx + IW'(1);
                s1_last <= (r_cnt == ar_len);
                r_done  <= (r_cnt == ar_len);
            end
            if (r_advance) begin
                s1_valid     <= ram_re;
                s_axi_rvalid <= s1_valid;
                s_axi_rlast  <= s1_valid && s1_last;
                if (s1_valid) s_axi_rdata <= (r_err == OKAY) ? ram_rdata : '0;
            end
        end
    end

    sdp_ram #(
        .WIDTH (DATA_BUS_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (s_axi_aclk),
        .we    (ram_we),
        .waddr (w_idx),
        .wdata (s_axi_wdata),
        .wbe   (s_axi_wstrb),
        .re    (ram_re),
        .raddr (r_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi3_slave_ram.sv
// tb/tb_axi3_slave_ram.sv - table-driven write/read-back bench for axi3_slave_ram
module tb_axi3_slave_ram;
    import axi3_pkg::*;

    logic        clk, rst;
    logic [2:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_data [32];
    logic        rd_last [32];
    logic [1:0]  rd_resp [32];
    logic [2:0]  rd_id   [32];
    int          rd_cnt, rd_lat;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [2:0]  id;
        logic [31:0] seed;
        logic [1:0]  exp;
        logic        toggle;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    axi3_slave_ram dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [2:0] id, input logic [31:0] seed,
                             input logic [3:0] strb, input int bad_beat, input int last_beat,
                             output logic [1:0] resp, output logic [2:0] b_id, output logic b_prompt);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_handshake", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= last_beat; i++) begin
            @(negedge clk);
            wvalid = 1'b1;
            wdata  = seed + 32'(i);
            wstrb  = strb;
            wid    = (i == bad_beat) ? 3'(id + 3'd1) : id;
            wlast  = (i == last_beat);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            check("w_handshake", 32'(wready), 32'd1);
            @(posedge clk); #1;
        end
        b_prompt = bvalid;
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_handshake", 32'(bvalid), 32'd1);
        resp = bresp;
        b_id = bid;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [2:0] id, input logic toggle);
        int n, cyc;
        logic stalled, hl;
        logic [31:0] hd;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rd_cnt = 0; rd_lat = -1; stalled = 1'b0; cyc = 0; hd = '0; hl = 1'b0;
        while (cyc < 100 && rd_cnt < 32 && !(rd_cnt > 0 && rd_last[rd_cnt-1])) begin
            @(negedge clk);
            cyc++;
            if (rvalid && rd_lat < 0) rd_lat = cyc - 1;
            if (stalled) begin
                check("stall_rdata", rdata, hd);
                check("stall_rlast", 32'(rlast), 32'(hl));
            end
            rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (rvalid && rready) begin
                rd_data[rd_cnt] = rdata;
                rd_last[rd_cnt] = rlast;
                rd_resp[rd_cnt] = rresp;
                rd_id[rd_cnt]   = rid;
                rd_cnt++;
            end
            stalled = rvalid && !rready;
            hd = rdata;
            hl = rlast;
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic verify_read(input string tag, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input logic [2:0] id,
                               input logic [31:0] seed, input logic [1:0] exp_resp, input logic toggle);
        logic [31:0] exp;
        axi_read(addr, len, burst, size, id, toggle);
        check({tag, "_beats"}, 32'(rd_cnt), 32'(len) + 32'd1);
        check({tag, "_lat"}, 32'(rd_lat), 32'd2);
        for (int i = 0; i < rd_cnt; i++) begin
            if (exp_resp != OKAY)    exp = '0;
            else if (burst == FIXED) exp = seed + 32'(len);
            else                     exp = seed + 32'(i);
            check($sformatf("%s_rdata%0d", tag, i), rd_data[i], exp);
            check($sformatf("%s_rlast%0d", tag, i), 32'(rd_last[i]), 32'(i == int'(len)));
            check($sformatf("%s_rresp_rid%0d", tag, i), 32'({rd_resp[i], rd_id[i]}), 32'({exp_resp, id}));
        end
    endtask

    logic [1:0] resp;
    logic [2:0] b_id;
    logic       bp;
    int         n, cnt;

    initial begin
        vecs[0] = '{32'h1000_0000, 4'd15, INCR,  3'd2, 3'd3, 32'h0000_0000, OKAY,   1'b0};
        vecs[1] = '{32'h1000_0040, 4'd15, INCR,  3'd2, 3'd1, 32'h0000_0100, OKAY,   1'b1};
        vecs[2] = '{32'h1000_0100, 4'd3,  INCR,  3'd2, 3'd5, 32'h0000_A000, OKAY,   1'b0};
        vecs[3] = '{32'h1000_0200, 4'd3,  FIXED, 3'd2, 3'd6, 32'h0000_00B0, OKAY,   1'b1};
        vecs[4] = '{32'h1000_0FF0, 4'd3,  INCR,  3'd2, 3'd7, 32'h0000_5500, OKAY,   1'b0};
        vecs[5] = '{32'h0FFF_FFF0, 4'd0,  INCR,  3'd2, 3'd4, 32'hDEAD_0000, DECERR, 1'b0};
        vecs[6] = '{32'h1000_0FFC, 4'd1,  INCR,  3'd2, 3'd2, 32'h0000_BAD0, DECERR, 1'b0};
        vecs[7] = '{32'h1000_0300, 4'd3,  WRAP,  3'd2, 3'd1, 32'h0000_00C0, SLVERR, 1'b0};
        vecs[8] = '{32'h1000_0310, 4'd1,  INCR,  3'd1, 3'd0, 32'h0000_00D0, SLVERR, 1'b0};
        vecs[9] = '{32'h1000_0400, 4'd2,  2'b11, 3'd2, 3'd2, 32'h0000_00E0, SLVERR, 1'b0};

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_handshakes", 32'({awready, wready, bvalid, arready, rvalid, rlast}), 32'd0);
        check("rst_resp_ids", 32'({bresp, rresp, bid, rid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        for (int k = 0; k < NV; k++) begin
            axi_write(vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].size, vecs[k].id,
                      vecs[k].seed, 4'hF, -1, int'(vecs[k].len), resp, b_id, bp);
            check($sformatf("v%0d_bresp", k), 32'(resp), 32'(vecs[k].exp));
            check($sformatf("v%0d_bid", k), 32'(b_id), 32'(vecs[k].id));
            check($sformatf("v%0d_bvalid_next", k), 32'(bp), 32'd1);
            verify_read($sformatf("v%0d", k), vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].size,
                        vecs[k].id, vecs[k].seed, vecs[k].exp, vecs[k].toggle);
        end

        // Out-of-range writes must not have aliased onto the top words or word 0.
        verify_read("decerr_kept", 32'h1000_0FF0, 4'd3, INCR, 3'd2, 3'd0, 32'h0000_5500, OKAY, 1'b0);

        axi_write(32'h1000_0500, 4'd0, INCR, 3'd2, 3'd1, 32'h1122_3344, 4'hF, -1, 0, resp, b_id, bp);
        check("strb_init_bresp", 32'(resp), 32'(OKAY));
        axi_write(32'h1000_0500, 4'd0, INCR, 3'd2, 3'd1, 32'hAABB_CCDD, 4'b0011, -1, 0, resp, b_id, bp);
        check("strb_bresp", 32'(resp), 32'(OKAY));
        verify_read("strb", 32'h1000_0500, 4'd0, INCR, 3'd2, 3'd1, 32'h1122_CCDD, OKAY, 1'b0);

        axi_write(32'h1000_0600, 4'd3, INCR, 3'd2, 3'd2, 32'h0000_0600, 4'hF, -1, 3, resp, b_id, bp);
        check("wid_init_bresp", 32'(resp), 32'(OKAY));
        axi_write(32'h1000_0600, 4'd3, INCR, 3'd2, 3'd2, 32'h0000_0700, 4'hF, 2, 3, resp, b_id, bp);
        check("wid_bresp", 32'(resp), 32'(SLVERR));
        verify_read("wid_keep", 32'h1000_060C, 4'd0, INCR, 3'd2, 3'd2, 32'h0000_0603, OKAY, 1'b0);

        axi_write(32'h1000_0700, 4'd7, INCR, 3'd2, 3'd4, 32'h0, 4'hF, -1, 3, resp, b_id, bp);
        check("early_wlast_bresp", 32'(resp), 32'(SLVERR));
        check("early_wlast_bvalid_next", 32'(bp), 32'd1);
        axi_write(32'h1000_0780, 4'd1, INCR, 3'd2, 3'd4, 32'h0, 4'hF, -1, 3, resp, b_id, bp);
        check("late_wlast_bresp", 32'(resp), 32'(SLVERR));

        // Reset while beat 5 of a 16-beat read is on the bus.
        @(negedge clk);
        arid = 3'd3; araddr = 32'h1000_0000; arlen = 4'd15; arburst = INCR; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("rst_ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0; cnt = 0;
        while (cnt < 6 && n < 50) begin
            @(negedge clk);
            n++;
            if (rvalid) cnt++;
        end
        check("rst_beats_before", 32'(cnt), 32'd6);
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_arready", 32'(arready), 32'd0);
        @(negedge clk);
        check("rst_hold_rvalid_arready", 32'({rvalid, arready}), 32'd0);
        rst = 1'b0;
        rready = 1'b0;
        @(posedge clk); #1;
        check("rst_rel_arready", 32'(arready), 32'd1);
        verify_read("post_rst", 32'h1000_0000, 4'd15, INCR, 3'd2, 3'd3, 32'h0, OKAY, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi3_slave_ram.md
# axi3_slave_ram

AXI3 slave memory model that terminates the write-then-read-back traffic generated by the team's AXI3 burst master. It accepts INCR/FIXED bursts of up to 16 beats on independent write and read paths, stores data in an internal simple-dual-port RAM, and returns OKAY/SLVERR/DECERR responses. It sits directly downstream of the master, in simulation benches and in FPGA self-test builds.

## Interface
- BASE_ADDR, 32'h1000_0000, byte address mapped to RAM word 0
- ADDR_BUS_WIDTH, 32, AXI address width
- DATA_BUS_WIDTH, 32, data width: 32/64/128/256
- ID_WIDTH, 3, width of the awid/wid/bid/arid/rid fields
- MEM_DEPTH, 1024, RAM depth in words; must be a power of two

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- s_axi_aclk  in  1  interface clock
- s_axi_areset  in  1  asynchronous reset, active-high
- s_axi_awid, awaddr, awlen, awsize, awburst  in  ID_WIDTH/ADDR_BUS_WIDTH/4/3/2  write address
- s_axi_awvalid in 1, s_axi_awready out 1  write address handshake
- s_axi_wid, wdata, wstrb, wlast  in  ID_WIDTH/DATA_BUS_WIDTH/DATA_BUS_WIDTH/8/1  write data
- s_axi_wvalid in 1, s_axi_wready out 1  write data handshake
- s_axi_bid  out  ID_WIDTH; s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1  write response
- s_axi_arid, araddr, arlen, arsize, arburst  in  ID_WIDTH/ADDR_BUS_WIDTH/4/3/2  read address
- s_axi_arvalid in 1, s_axi_arready out 1  read address handshake
- s_axi_rid  out  ID_WIDTH; rdata  out  DATA_BUS_WIDTH; rresp  out  2; rlast  out  1; rvalid  out  1; s_axi_rready  in  1  read data

## Operation
- The write and read paths are fully independent FSMs and may run concurrently.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches id, start word index, len, burst and an error code, then goes to W_DATA.
  - W_DATA: wready=1. Each W handshake writes RAM with a per-byte wstrb mask at the current index, increments the beat counter and advances the index (INCR: +1; FIXED: hold).
  - W_DATA ends on the beat with wlast=1 and goes to W_RESP.
  - W_RESP: bvalid=1 with bid=latched awid, until bready; then W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. AR handshake latches the same fields, then goes to R_DATA.
  - R_DATA: the RAM is read whenever the output register is empty or being consumed (!rvalid || rready).
  - rlast=1 on beat arlen. The handshake on that beat returns the FSM to R_IDLE.
- Address decode:
  - word index = (addr − BASE_ADDR) >> log2(DATA_BUS_WIDTH/8).
  - Out of range (addr < BASE_ADDR or index + len ≥ MEM_DEPTH): DECERR; writes dropped, reads return 0.
- Error precedence is DECERR > SLVERR > OKAY. SLVERR is raised for any of:
  - burst = WRAP or reserved
  - size ≠ log2(DATA_BUS_WIDTH/8)
  - wid ≠ latched awid on any beat
  - wlast position ≠ awlen
- On SLVERR, write data is still accepted until wlast, but the RAM is not written. Reads on SLVERR return 0.
- rresp is constant over a burst. rid = latched arid.

## Timing
- Reset values: every ready/valid/last output 0, bresp/rresp 0, id/data outputs 0, both FSMs idle. RAM contents are not reset.
- awready and arready are registered: 1 on the first clock after reset release, 0 in the cycle after their handshake.
- Write: bvalid rises 1 cycle after the wlast handshake.
- Read: first rvalid 2 cycles after the AR handshake (1 RAM read + output register). With rready held at 1, beats are back-to-back: a 16-beat burst completes 17 cycles after the AR handshake.
- rdata/rid/rresp/rlast stay stable while rvalid=1 and rready=0.
- Write and read to the same word in the same cycle: the read returns the old data (read-first).
- Reset asserted mid-burst: immediate return to idle. The partial write is not rolled back and no B response is issued.
- Early wlast: the burst is closed and SLVERR is returned. No wlast on beat awlen: further beats are accepted (RAM not written) until wlast, then SLVERR is returned.

## Structure
- Package axi3_pkg:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - burst enum: FIXED=2'b00, INCR=2'b01, WRAP=2'b10
  - write FSM state typedef and read FSM state typedef
- Sub-module sdp_ram: one write port with byte enables, one synchronous read-first read port, parameterised by width and depth.

## Test plan
- Write INCR at 0x1000_0000, awlen=15, data 0..15, all strobes → bresp=OKAY. Read back the same burst → rdata 0..15, rlast on beat 15, rresp=OKAY, rid=arid.
- Read with rready toggling 1,0,1,0 → every rdata beat held stable while stalled, no beat lost or duplicated, 16 beats total.
- awaddr=0x0FFF_FFF0 → bresp=DECERR, RAM unchanged. araddr at the last word with arlen=1 → rresp=DECERR, rdata=0.
- awburst=WRAP → SLVERR. wlast on beat 3 of awlen=7 → SLVERR, bvalid 1 cycle later. wid≠awid → SLVERR.
- wstrb=4'b0011 writing 0xAABBCCDD over 0x11223344 → read back returns 0x1122CCDD.
- Assert s_axi_areset mid-read (beat 5) → rvalid=0 and arready=0 during reset, arready=1 one cycle after release. A new burst then completes normally.
